// File: rtl/vec_pe_pkg.sv
// Shared definitions for the vector PE and its dispatcher: opcodes, sequencer states and
// opcode classification helpers.
package vec_pe_pkg;

   localparam logic [7:0] OpVadd     = 8'h00;
   localparam logic [7:0] OpVmul     = 8'h01;
   localparam logic [7:0] OpVdot     = 8'h02;
   localparam logic [7:0] OpVaddvarp = 8'h03;
   localparam logic [7:0] OpVmulvarp = 8'h04;
   localparam logic [7:0] OpVdotvarp = 8'h05;
   localparam logic [7:0] OpVsub     = 8'h06;
   localparam logic [7:0] OpVsubvarp = 8'h07;

   // Fixed PE cycles on top of the per-op multiply iterations.
   localparam int unsigned PE_OVERHEAD = 3;

   typedef enum logic [2:0] {
      StIdle,
      StRdA,
      StRdB,
      StRdC,
      StCapC,
      StIssue,
      StWb
   } state_e;

   function automatic logic is_mul(input logic [7:0] instr);
      return (instr == OpVmul) || (instr == OpVmulvarp);
   endfunction

   function automatic logic is_dot(input logic [7:0] instr);
      return (instr == OpVdot) || (instr == OpVdotvarp);
   endfunction

   function automatic logic is_varp(input logic [7:0] instr);
      return (instr == OpVaddvarp) || (instr == OpVmulvarp) || (instr == OpVdotvarp) ||
             (instr == OpVsubvarp);
   endfunction

endpackage

// File: rtl/vector_pe_dispatcher.sv
// Walks a vector command word by word: fetch operands from the register file, run one PE
// start/done handshake per word, write the result back, with an ISSUE watchdog.
module vector_pe_dispatcher
   import vec_pe_pkg::*;
#(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned VL_W   = 8,
   parameter int unsigned WDOG   = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [7:0]        cmd_instr,
   input  logic [9:0]        cmd_sew,
   input  logic [3:0]        cmd_vap,
   input  logic [VL_W-1:0]   cmd_vl,
   input  logic [ADDR_W-1:0] cmd_vs1,
   input  logic [ADDR_W-1:0] cmd_vs2,
   input  logic [ADDR_W-1:0] cmd_vs3,
   input  logic [ADDR_W-1:0] cmd_vd,
   output logic              rf_ren,
   output logic [ADDR_W-1:0] rf_raddr,
   input  logic [31:0]       rf_rdata,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic [31:0]       rf_wdata,
   output logic              pe_start,
   output logic [7:0]        pe_instruction,
   output logic [31:0]       pe_opA,
   output logic [31:0]       pe_opB,
   output logic [31:0]       pe_opC,
   output logic [9:0]        pe_SEW,
   output logic [3:0]        pe_vap,
   input  logic              pe_done,
   input  logic [31:0]       pe_peout,
   output logic              busy,
   output logic              cmd_done,
   output logic              err
);

   localparam int unsigned WdW = $clog2(WDOG + 1);

   state_e              state_q, state_d;
   logic [VL_W-1:0]     idx_q, vl_q;
   logic [ADDR_W-1:0]   vs1_q, vs2_q, vs3_q, vd_q;
   logic [31:0]         res_q;
   logic                armed_q;
   logic [WdW-1:0]      wdog_q;
   logic                done_q, err_q;
   logic                accept, illegal, fire, expire, wb_last;

   assign accept  = cmd_valid && cmd_ready;
   assign illegal = cmd_instr > OpVsubvarp;
   // done is sticky from the previous op, so only trust it once our own start has been seen.
   assign fire    = (state_q == StIssue) && armed_q && pe_done;
   assign expire  = (state_q == StIssue) && !fire && (wdog_q == WdW'(WDOG - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= StIdle;
         idx_q          <= '0;
         vl_q           <= '0;
         vs1_q          <= '0;
         vs2_q          <= '0;
         vs3_q          <= '0;
         vd_q           <= '0;
         pe_instruction <= '0;
         pe_SEW         <= '0;
         pe_vap         <= '0;
         pe_opA         <= '0;
         pe_opB         <= '0;
         pe_opC         <= '0;
         res_q          <= '0;
         armed_q        <= 1'b0;
         wdog_q         <= '0;
         done_q         <= 1'b0;
         err_q          <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  vl_q           <= cmd_vl;
                  vs1_q          <= cmd_vs1;
                  vs2_q          <= cmd_vs2;
                  vs3_q          <= cmd_vs3;
                  vd_q           <= cmd_vd;
                  pe_instruction <= cmd_instr;
                  pe_SEW         <= cmd_sew;
                  pe_vap         <= cmd_vap;
                  idx_q          <= '0;
                  if (cmd_vl == '0 || illegal) begin
                     done_q <= 1'b1;
                     err_q  <= illegal;
                  end
               end
            end
            StRdB:  pe_opA <= rf_rdata;
            StRdC:  pe_opB <= rf_rdata;
            StCapC: begin
               pe_opC  <= is_dot(pe_instruction) ? rf_rdata : 32'd0;
               armed_q <= 1'b0;
               wdog_q  <= '0;
            end
            StIssue: begin
               armed_q <= 1'b1;
               wdog_q  <= wdog_q + 1'b1;
               if (fire) begin
                  res_q <= pe_peout;
               end else if (expire) begin
                  done_q <= 1'b1;
                  err_q  <= 1'b1;
               end
            end
            StWb:    idx_q <= idx_q + 1'b1;
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d  = state_q;
      rf_ren   = 1'b0;
      rf_raddr = '0;
      rf_we    = 1'b0;
      rf_waddr = '0;
      rf_wdata = '0;
      pe_start = 1'b0;
      wb_last  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (accept) state_d = (cmd_vl == '0 || illegal) ? StIdle : StRdA;
         end
         StRdA: begin
            rf_ren   = 1'b1;
            rf_raddr = vs1_q + ADDR_W'(idx_q);
            state_d  = StRdB;
         end
         StRdB: begin
            rf_ren   = 1'b1;
            rf_raddr = vs2_q + ADDR_W'(idx_q);
            state_d  = StRdC;
         end
         StRdC: begin
            if (is_dot(pe_instruction)) begin
               rf_ren   = 1'b1;
               rf_raddr = vs3_q + ADDR_W'(idx_q);
            end
            state_d = StCapC;
         end
         StCapC: state_d = StIssue;
         StIssue: begin
            pe_start = !(armed_q && pe_done);
            if (fire)        state_d = StWb;
            else if (expire) state_d = StIdle;
         end
         StWb: begin
            rf_we    = 1'b1;
            rf_waddr = vd_q + ADDR_W'(idx_q);
            rf_wdata = res_q;
            wb_last  = (idx_q == vl_q - 1'b1);
            state_d  = wb_last ? StIdle : StRdA;
         end
         default: state_d = StIdle;
      endcase
   end

   assign cmd_ready = (state_q == StIdle);
   assign busy      = (state_q != StIdle);
   assign cmd_done  = done_q || wb_last;
   assign err       = err_q;

endmodule
